// File: rtl/tt_sweep_checker_pkg.sv
// Shared definitions for the truth-table sweep checker: FSM encoding, default
// geometry and the settle-counter width rule.
package tt_sweep_checker_pkg;

    localparam int DEF_N_IN   = 3;
    localparam int DEF_SETTLE = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Width needed to hold SETTLE, never narrower than one bit.
    function automatic int cnt_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/tt_sweep_checker_settle_timer.sv
// Load/decrement hold counter; zero marks the cycle in which the current
// input vector has settled long enough to be sampled.
module settle_timer
    import tt_sweep_checker_pkg::*;
#(
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = cnt_width(SETTLE);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps a combinational DUT through every input vector, captures its truth
// table and compares it with an expected table latched at start.
module tt_sweep_checker
    import tt_sweep_checker_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = DEF_SETTLE,
    localparam int TT_W  = 2 ** N_IN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TT_W-1:0]   expected,
    input  logic              y_in,
    output logic [N_IN-1:0]   x_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [TT_W-1:0]   tt_out,
    output logic [N_IN:0]     mismatch_cnt
);

    state_t            state, state_nxt;
    logic [N_IN-1:0]   idx;
    logic [TT_W-1:0]   exp_q;
    logic              timer_load;
    logic              timer_dec;
    logic              timer_zero;
    logic              capture;
    logic              last_vec;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .dec  (timer_dec),
        .zero (timer_zero)
    );

    assign last_vec = (idx == N_IN'(TT_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt  = ST_RUN;
                    timer_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (!timer_zero) begin
                    timer_dec = 1'b1;
                end else begin
                    capture = 1'b1;
                    if (last_vec) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        timer_load = 1'b1;
                    end
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: synchronous reset clears all state including exp_q, so a sweep
    // aborted by rst leaves nothing behind for the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            x_out        <= '0;
            exp_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            tt_out       <= '0;
            mismatch_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        idx          <= '0;
                        x_out        <= '0;
                        exp_q        <= expected;
                        tt_out       <= '0;
                        mismatch_cnt <= '0;
                        pass         <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (capture) begin
                        tt_out[idx]  <= y_in;
                        mismatch_cnt <= mismatch_cnt + (N_IN+1)'(y_in != exp_q[idx]);
                        if (last_vec) begin
                            x_out <= '0;
                        end else begin
                            idx   <= idx + N_IN'(1);
                            x_out <= idx + N_IN'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (tt_out == exp_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: three instances (SETTLE 5, 0, 1) driving
// table-defined or delayed-AND DUT models, checked against a truth-table model.
module tb_tt_sweep_checker;

    localparam int TW = 8;
    localparam int NI = 3;

    function automatic int settle_of(input int g);
        return (g == 0) ? 5 : ((g == 1) ? 0 : 1);
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start      [NI];
    logic [7:0] expected   [NI];
    logic       y_in       [NI];
    logic [2:0] x_out      [NI];
    logic       busy       [NI];
    logic       done       [NI];
    logic       pass       [NI];
    logic [7:0] tt_out     [NI];
    logic [3:0] mm         [NI];
    logic       delay_mode [NI];
    logic [7:0] fn_tt      [NI];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic [2:0] d1 = '0, d2 = '0, d3 = '0;
        always @(posedge clk) begin
            d1 <= x_out[g];
            d2 <= d1;
            d3 <= d2;
        end
        assign y_in[g] = delay_mode[g] ? (&d3) : fn_tt[g][x_out[g]];

        tt_sweep_checker #(.N_IN(3), .SETTLE(settle_of(g))) dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start[g]),
            .expected     (expected[g]),
            .y_in         (y_in[g]),
            .x_out        (x_out[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .pass         (pass[g]),
            .tt_out       (tt_out[g]),
            .mismatch_cnt (mm[g])
        );
    end

    typedef struct {
        int         inst;
        logic       delay;
        logic [7:0] fn;
        logic [7:0] exp_tt;
        logic [7:0] want_tt;
        int         want_mm;
        logic       want_pass;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Reference: the captured table is the DUT's function; compare bitwise.
    function automatic vec_t mk(input int inst, input logic delay, input logic [7:0] fn,
                                input logic [7:0] exp_tt, input string name);
        vec_t v;
        v.inst      = inst;
        v.delay     = delay;
        v.fn        = fn;
        v.exp_tt    = exp_tt;
        v.want_tt   = fn;
        v.want_mm   = $countones(fn ^ exp_tt);
        v.want_pass = (fn == exp_tt);
        v.name      = name;
        return v;
    endfunction

    task automatic check_idle_zero(input int i, input string name);
        check({name, "/x_out"},  32'(x_out[i]),  0);
        check({name, "/busy"},   32'(busy[i]),   0);
        check({name, "/done"},   32'(done[i]),   0);
        check({name, "/pass"},   32'(pass[i]),   0);
        check({name, "/tt_out"}, 32'(tt_out[i]), 0);
        check({name, "/mm"},     32'(mm[i]),     0);
    endtask

    // Starts a sweep on instance i; want_mm < 0 means "at least one mismatch".
    task automatic run_sweep(input int i, input logic [7:0] exp_tt, input logic [7:0] want_tt,
                             input int want_mm, input logic want_pass, input bit pulses,
                             input string name);
        int         lim;
        int         done_at;
        bit         overlap;
        bit         seq_ok;
        logic [2:0] seq[$];
        lim     = TW * (settle_of(i) + 1) + 1;
        done_at = -1;
        overlap = 1'b0;
        start[i]    = 1'b1;
        expected[i] = exp_tt;
        tick();
        start[i]    = 1'b0;
        expected[i] = ~exp_tt;
        check({name, "/busy_after_start"}, 32'(busy[i]), 1);
        seq.push_back(x_out[i]);
        for (int n = 1; n <= lim + 20; n++) begin
            tick();
            if (busy[i] && done[i]) overlap = 1'b1;
            if (busy[i] && (x_out[i] != seq[$])) seq.push_back(x_out[i]);
            if (done[i]) begin
                done_at = n;
                break;
            end
            start[i] = pulses && (n == 9 || n == 19);
        end
        start[i] = 1'b0;
        check({name, "/done_edge"}, 32'(done_at), 32'(lim));
        check({name, "/busy_done_overlap"}, 32'(overlap), 0);
        seq_ok = (seq.size() == TW + 1);
        for (int k = 0; k < seq.size() && seq_ok; k++) begin
            if (seq[k] != 3'(k % TW)) seq_ok = 1'b0;
        end
        check({name, "/x_sequence"}, 32'(seq_ok), 1);
        if (want_mm >= 0) begin
            check({name, "/tt_out"}, 32'(tt_out[i]), 32'(want_tt));
            check({name, "/mismatch_cnt"}, 32'(mm[i]), 32'(want_mm));
        end else begin
            check({name, "/mismatch_nonzero"}, 32'(mm[i] >= 1), 1);
        end
        check({name, "/pass"}, 32'(pass[i]), 32'(want_pass));
    endtask

    task automatic check_hold(input vec_t v);
        tick();
        tick();
        check({v.name, "/done_pulse"}, 32'(done[v.inst]),   0);
        check({v.name, "/idle_busy"},  32'(busy[v.inst]),   0);
        check({v.name, "/pass_held"},  32'(pass[v.inst]),   32'(v.want_pass));
        check({v.name, "/tt_held"},    32'(tt_out[v.inst]), 32'(v.want_tt));
    endtask

    initial begin
        vec_t v;
        logic [7:0] r;
        for (int i = 0; i < NI; i++) begin
            start[i]      = 1'b0;
            expected[i]   = '0;
            delay_mode[i] = 1'b0;
            fn_tt[i]      = 8'h80;
        end

        rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < NI; i++) check_idle_zero(i, $sformatf("reset%0d", i));
        rst = 1'b0;
        tick();

        vecs.push_back(mk(0, 1'b0, 8'h80, 8'h80, "and3"));
        vecs.push_back(mk(0, 1'b0, 8'hFE, 8'h80, "or3_faulty"));
        vecs.push_back(mk(1, 1'b0, 8'h80, 8'h80, "and3_settle0"));
        vecs.push_back(mk(0, 1'b1, 8'h80, 8'h80, "and3_delayed_s5"));
        vecs.push_back(mk(1, 1'b0, 8'h00, 8'hFF, "all_wrong_s0"));
        for (int k = 0; k < 6; k++) begin
            r = 8'($urandom);
            vecs.push_back(mk(int'($urandom_range(0, 2)), 1'b0, r,
                              ($urandom_range(0, 1) == 1) ? r : 8'($urandom),
                              $sformatf("random%0d", k)));
        end

        foreach (vecs[j]) begin
            v = vecs[j];
            delay_mode[v.inst] = v.delay;
            fn_tt[v.inst]      = v.fn;
            run_sweep(v.inst, v.exp_tt, v.want_tt, v.want_mm, v.want_pass, 1'b0, v.name);
            check_hold(v);
        end

        // start pulses mid-sweep are ignored; then a restart in the done cycle
        delay_mode[0] = 1'b0;
        fn_tt[0]      = 8'h80;
        run_sweep(0, 8'h80, 8'h80, 0, 1'b1, 1'b1, "start_ignored");
        fn_tt[0] = 8'hFE;
        run_sweep(0, 8'h80, 8'hFE, 6, 1'b0, 1'b0, "back_to_back");
        tick();

        // reset while capturing vector 3, then a clean sweep five edges later
        fn_tt[0]    = 8'h80;
        start[0]    = 1'b1;
        expected[0] = 8'h80;
        tick();
        start[0] = 1'b0;
        repeat (19) tick();
        check("midrst/x_before", 32'(x_out[0]), 3);
        check("midrst/busy_before", 32'(busy[0]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero(0, "midrst");
        repeat (4) tick();
        run_sweep(0, 8'h80, 8'h80, 0, 1'b1, 1'b0, "after_rst");

        // three-cycle DUT latency is too long for SETTLE=1
        delay_mode[2] = 1'b1;
        run_sweep(2, 8'h80, 8'h00, -1, 1'b0, 1'b0, "delayed_s1");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
